// File: rtl/ntt_pkg.sv
// Shared defaults, bank-state type and slot permutation for the 8-point NTT loader.
package ntt_pkg;

    localparam int unsigned NTT_DATA_W = 8;
    localparam int unsigned NTT_N      = 8;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_e;

    function automatic logic [2:0] bitrev3(input logic [2:0] k);
        return {k[0], k[1], k[2]};
    endfunction

endpackage

// File: rtl/ntt_frame_bank.sv
// One frame buffer of the ping/pong pair: N coefficient slots, captured modulus
// and the EMPTY/FILLING/FULL occupancy state.
module ntt_frame_bank
    import ntt_pkg::*;
#(
    parameter int unsigned DATA_W = NTT_DATA_W,
    parameter int unsigned N      = NTT_N
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                wr_en_i,
    input  logic [2:0]          wr_slot_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic                wr_first_i,
    input  logic [DATA_W-1:0]   wr_mod_i,
    input  logic                wr_last_i,
    input  logic                consume_i,
    output bank_state_e         state_o,
    output logic [N*DATA_W-1:0] data_o,
    output logic [DATA_W-1:0]   mod_o
);

    bank_state_e       state_q, state_d;
    logic [DATA_W-1:0] mem_q [N];
    logic [DATA_W-1:0] mod_q;

    // A write and a consume never target the same bank in one cycle:
    // writes need a non-FULL bank, consumes need a FULL one.
    always_comb begin
        state_d = state_q;
        if (consume_i) begin
            state_d = EMPTY;
        end else if (wr_en_i) begin
            state_d = wr_last_i ? FULL : FILLING;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            mod_q   <= '0;
            for (int unsigned i = 0; i < N; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            if (wr_en_i) begin
                mem_q[wr_slot_i] <= wr_data_i;
            end
            if (wr_en_i && wr_first_i) begin
                mod_q <= wr_mod_i;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            data_o[i*DATA_W +: DATA_W] = mem_q[i];
        end
    end

    assign state_o = state_q;
    assign mod_o   = mod_q;

endmodule

// File: rtl/ntt8_bitrev_loader.sv
// Serial-to-frame loader for an 8-point NTT: writes beats in bit-reversed slot order
// into ping/pong banks. Optional NTT_LOADER_MODREDUCE_EN stores in_data % q.
module ntt8_bitrev_loader
    import ntt_pkg::*;
#(
    parameter int unsigned DATA_W = NTT_DATA_W,
    parameter int unsigned N      = NTT_N
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_last,
    input  logic [DATA_W-1:0]   mod,
    output logic                frame_valid,
    input  logic                frame_ready,
    output logic [N*DATA_W-1:0] frame_data,
    output logic [DATA_W-1:0]   frame_mod,
    output logic                frame_err
);

    logic [2:0]          wr_cnt_q, wr_cnt_d;
    logic                wr_bank_q, wr_bank_d;
    logic                rd_bank_q, rd_bank_d;
    logic                err_q, err_d;
    logic                accept, consume, beat_last;
    logic [DATA_W-1:0]   wr_data;
    bank_state_e         bank_state [2];
    logic [N*DATA_W-1:0] bank_data  [2];
    logic [DATA_W-1:0]   bank_mod   [2];

    assign in_ready    = (bank_state[wr_bank_q] != FULL);
    assign frame_valid = (bank_state[rd_bank_q] == FULL);
    assign frame_data  = bank_data[rd_bank_q];
    assign frame_mod   = bank_mod[rd_bank_q];
    assign frame_err   = err_q;
    assign accept      = in_valid && in_ready;
    assign consume     = frame_valid && frame_ready;
    assign beat_last   = (wr_cnt_q == 3'd7);

`ifdef NTT_LOADER_MODREDUCE_EN
    // Beat 0 reduces by the modulus arriving with it; later beats by the captured q.
    logic [DATA_W-1:0] q_eff;
    always_comb begin
        q_eff   = (wr_cnt_q == '0) ? mod : bank_mod[wr_bank_q];
        wr_data = (q_eff == '0) ? in_data : in_data % q_eff;
    end
`else
    assign wr_data = in_data;
`endif

    always_comb begin
        wr_cnt_d  = wr_cnt_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        err_d     = err_q;
        if (accept) begin
            wr_cnt_d = wr_cnt_q + 3'd1;
            if (beat_last) begin
                wr_bank_d = ~wr_bank_q;
            end
            if (in_last != beat_last) begin
                err_d = 1'b1;
            end
        end
        if (consume) begin
            rd_bank_d = ~rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q  <= '0;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wr_cnt_q  <= wr_cnt_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            err_q     <= err_d;
        end
    end

    for (genvar b = 0; b < 2; b++) begin : g_bank
        ntt_frame_bank #(
            .DATA_W (DATA_W),
            .N      (N)
        ) u_bank (
            .clk        (clk),
            .rst_n      (rst_n),
            .wr_en_i    (accept && (wr_bank_q == 1'(b))),
            .wr_slot_i  (bitrev3(wr_cnt_q)),
            .wr_data_i  (wr_data),
            .wr_first_i (wr_cnt_q == '0),
            .wr_mod_i   (mod),
            .wr_last_i  (beat_last),
            .consume_i  (consume && (rd_bank_q == 1'(b))),
            .state_o    (bank_state[b]),
            .data_o     (bank_data[b]),
            .mod_o      (bank_mod[b])
        );
    end

endmodule
